// File: rtl/counter_sched_pkg.sv
// Shared types, default sizes and the round-robin select helper for counter_sched.
package counter_sched_pkg;

  localparam int NUM_REQ_DEF = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int MAX_REQ     = 8;
  localparam int IDX_W       = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One-hot winner: first set req bit at or after ptr, wrapping modulo n.
  // Scanning offsets from high to low lets the smallest offset win.
  function automatic logic [MAX_REQ-1:0] rr_select(input logic [MAX_REQ-1:0] req,
                                                   input logic [IDX_W-1:0]   ptr,
                                                   input int                 n);
    logic [MAX_REQ-1:0] sel;
    int                 idx;
    sel = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (req[idx]) sel = MAX_REQ'(1) << idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Request/grant bundle between the requesters (master) and counter_sched (slave).
interface counter_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CNT_W-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       done;
  logic                     busy;
  logic [CNT_W-1:0]         q;

  modport master (output req, len, input grant, done, busy, q);
  modport slave  (input req, len, output grant, done, busy, q);
endinterface

// File: rtl/counter_sched_down_counter.sv
// Loadable down-counter that holds at zero instead of wrapping.
module sched_down_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] q_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] q_q;

  // Load has priority over decrement; decrement is gated at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (load_i) begin
      q_q <= load_val_i;
    end else if (en_i && (q_q != '0)) begin
      q_q <= q_q - 1'b1;
    end
  end

  assign q_o    = q_q;
  assign zero_o = (q_q == '0);

endmodule

// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one down-counter among NUM_REQ requesters.
// Optional feature macro: COUNTER_SCHED_ABORT_EN adds abort_i, which cancels
// the interval being counted without a done pulse.
//
// state | meaning
// IDLE  | no owner; arbitrate req starting at ptr
// COUNT | winner owns the counter, counting down to zero
// DONE  | one-cycle done pulse to the winner, grant still held
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef COUNTER_SCHED_ABORT_EN
  input  logic abort_i,
`endif
  counter_sched_if.slave bus
);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] done_q;
  logic               busy_q;

  logic [MAX_REQ-1:0] sel_full;
  logic [NUM_REQ-1:0] sel_d;
  logic [IDX_W-1:0]   sel_idx_d;
  logic [IDX_W-1:0]   ptr_next_d;
  logic               abort_d;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_zero;

`ifdef COUNTER_SCHED_ABORT_EN
  assign abort_d = abort_i && (state_q == COUNT);
`else
  assign abort_d = 1'b0;
`endif

  // Arbitration winner and its index, plus the post-service pointer.
  always_comb begin
    sel_full  = rr_select(MAX_REQ'(bus.req), ptr_q, NUM_REQ);
    sel_d     = sel_full[NUM_REQ-1:0];
    sel_idx_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_d[i]) sel_idx_d = IDX_W'(i);
    end
    ptr_next_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
  end

  // Counter load: winner's len at grant, or forced to zero on abort.
  always_comb begin
    cnt_load     = ((state_q == IDLE) && (|bus.req)) || abort_d;
    cnt_load_val = abort_d ? '0 : bus.len[sel_idx_d*CNT_W +: CNT_W];
  end

  sched_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .en_i      (state_q == COUNT),
    .q_o       (cnt_q),
    .zero_o    (cnt_zero)
  );

  // Scheduler FSM with registered grant/done/busy outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (|bus.req) begin
            grant_q <= sel_d;
            win_q   <= sel_idx_d;
            busy_q  <= 1'b1;
            state_q <= COUNT;
          end
        end
        COUNT: begin
          if (abort_d) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_next_d;
            state_q <= IDLE;
          end else if (cnt_zero) begin
            done_q  <= grant_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= ptr_next_d;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          done_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.q     = cnt_q;

endmodule

// File: tb/tb_counter_sched.sv
// Directed, table-driven bench for counter_sched (NUM_REQ=4, CNT_W=4).
module tb_counter_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef COUNTER_SCHED_ABORT_EN
  logic abort = 1'b0;
`endif

  counter_sched_if #(.NUM_REQ(4), .CNT_W(4)) bus ();

  counter_sched #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
`ifdef COUNTER_SCHED_ABORT_EN
    .abort_i(abort),
`endif
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;
    logic [3:0]  q;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic [3:0] qv);
    chk({tag, ".grant"}, int'(bus.grant), int'(g));
    chk({tag, ".done"},  int'(bus.done),  int'(d));
    chk({tag, ".busy"},  int'(bus.busy),  int'(b));
    chk({tag, ".q"},     int'(bus.q),     int'(qv));
  endtask

  initial begin
    logic [3:0] g;
    //          rst   req      len        grant    done     busy  q
    vecs[0]  = '{1'b1, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd3};
    vecs[2]  = '{1'b0, 4'b0000, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd2};
    vecs[3]  = '{1'b0, 4'b0000, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd1};
    vecs[4]  = '{1'b0, 4'b0000, 16'h0003, 4'b0001, 4'b0000, 1'b1, 4'd0};
    vecs[5]  = '{1'b0, 4'b0000, 16'h0003, 4'b0001, 4'b0001, 1'b1, 4'd0};
    vecs[6]  = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[7]  = '{1'b0, 4'b0010, 16'h0000, 4'b0010, 4'b0000, 1'b1, 4'd0};
    vecs[8]  = '{1'b0, 4'b0000, 16'h0000, 4'b0010, 4'b0010, 1'b1, 4'd0};
    vecs[9]  = '{1'b0, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 4'd0};
    vecs[10] = '{1'b0, 4'b0100, 16'h0F00, 4'b0100, 4'b0000, 1'b1, 4'd15};

    bus.req = '0;
    bus.len = '0;
    rst     = 1'b1;
    step();
    step();

    // Reset, single request len=3, len=0 request, then start of len=15.
    for (int i = 0; i < 11; i++) begin
      rst     = vecs[i].rst;
      bus.req = vecs[i].req;
      bus.len = vecs[i].len;
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].grant, vecs[i].done, vecs[i].busy, vecs[i].q);
    end

    // len=15 counts all the way down without wrapping.
    bus.req = '0;
    for (int k = 14; k >= 0; k--) begin
      step();
      expect_out($sformatf("len15_q%0d", k), 4'b0100, 4'b0000, 1'b1, 4'(k));
    end
    step();
    expect_out("len15_done", 4'b0100, 4'b0100, 1'b1, 4'd0);
    step();
    expect_out("len15_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Reset restores ptr=0; all requesting with len=1 rotates 0,1,2,3,0.
    rst = 1'b1;
    step();
    expect_out("rr_reset", 4'b0000, 4'b0000, 1'b0, 4'd0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.len = 16'h1111;
    for (int n = 0; n < 5; n++) begin
      g = 4'b0001 << (n % 4);
      step();
      expect_out($sformatf("rr%0d_load", n), g, 4'b0000, 1'b1, 4'd1);
      step();
      expect_out($sformatf("rr%0d_zero", n), g, 4'b0000, 1'b1, 4'd0);
      step();
      expect_out($sformatf("rr%0d_done", n), g, g, 1'b1, 4'd0);
      if (n == 4) bus.req = '0;
      step();
      expect_out($sformatf("rr%0d_idle", n), 4'b0000, 4'b0000, 1'b0, 4'd0);
    end

    // Drop req and shrink len mid-count: original len=5 still runs out.
    bus.req = 4'b0010;
    bus.len = 16'h0050;
    step();
    expect_out("drop_load", 4'b0010, 4'b0000, 1'b1, 4'd5);
    bus.req = '0;
    bus.len = 16'h0020;
    for (int k = 4; k >= 0; k--) begin
      step();
      expect_out($sformatf("drop_q%0d", k), 4'b0010, 4'b0000, 1'b1, 4'(k));
    end
    step();
    expect_out("drop_done", 4'b0010, 4'b0010, 1'b1, 4'd0);
    step();
    expect_out("drop_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

    // Reset while counting at q=2: no done, and requester 0 wins next.
    bus.req = 4'b0100;
    bus.len = 16'h0400;
    step();
    expect_out("rstc_load", 4'b0100, 4'b0000, 1'b1, 4'd4);
    bus.req = '0;
    step();
    step();
    expect_out("rstc_q2", 4'b0100, 4'b0000, 1'b1, 4'd2);
    rst = 1'b1;
    step();
    expect_out("rstc_clear", 4'b0000, 4'b0000, 1'b0, 4'd0);
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.len = 16'h1111;
    step();
    expect_out("rstc_win0", 4'b0001, 4'b0000, 1'b1, 4'd1);
    bus.req = '0;
    step();
    step();
    expect_out("rstc_done", 4'b0001, 4'b0001, 1'b1, 4'd0);
    step();
    expect_out("rstc_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);

`ifdef COUNTER_SCHED_ABORT_EN
    // Abort requester 2 mid-count: no done, requester 3 gets priority next.
    bus.req = 4'b0100;
    bus.len = 16'h0600;
    step();
    expect_out("abort_load", 4'b0100, 4'b0000, 1'b1, 4'd6);
    bus.req = '0;
    step();
    expect_out("abort_q5", 4'b0100, 4'b0000, 1'b1, 4'd5);
    abort = 1'b1;
    step();
    expect_out("abort_idle", 4'b0000, 4'b0000, 1'b0, 4'd0);
    abort   = 1'b0;
    bus.req = 4'b1111;
    bus.len = 16'h1111;
    step();
    expect_out("abort_next", 4'b1000, 4'b0000, 1'b1, 4'd1);
    bus.req = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
# counter_sched

Round-robin scheduler that shares one CNT_W-bit down-counter among NUM_REQ requesters. Each requester asks for an interval of `len` cycles. The block grants one requester at a time, loads the counter, and counts it down to zero. It then pulses that requester's `done` and moves round-robin priority past it. It sits between the control blocks that need timed intervals and the single physical counter resource.

## Interface
- NUM_REQ, default 4: number of requesters; legal values 2..8.
- CNT_W, default 4: counter width; legal values 2..16.
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  request bit per requester; level-sensitive.
- len  in  NUM_REQ*CNT_W  interval length; requester i uses bits [i*CNT_W +: CNT_W].
- grant  out  NUM_REQ  one-hot owner of the counter; all zero when idle.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- busy  out  1  high whenever the counter is owned.
- q  out  CNT_W  current count value.
- abort  in  1  cancels the current interval; present only with COUNTER_SCHED_ABORT_EN.

## Operation
- The FSM has three states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is high, select the winner by rotating priority, starting at ptr.
  - On the edge, load q with the winner's len, set grant to the winner, set busy=1, and go to COUNT.
  - With no req, stay in IDLE with q=0.
- COUNT:
  - If q!=0, decrement q on each edge.
  - If q==0, go to DONE on the edge. q stays 0.
- DONE:
  - done[winner]=1 for exactly this cycle; grant is still asserted.
  - On the edge: ptr <= (winner+1) mod NUM_REQ, grant <= 0, busy <= 0, go to IDLE.
- Arbitration rules:
  - req and len are sampled only in IDLE.
  - len is captured at grant; changes to len during COUNT are ignored.
  - Dropping req during COUNT does not stop the interval; it completes and done still pulses.
  - The requester must drop req in the DONE cycle or it competes again at the next IDLE.
- Round-robin: after requester i is served, requester i+1 has highest priority, wrapping from NUM_REQ-1 to 0. With a single active requester, it is re-granted every time.
- Arithmetic: the counter is unsigned, CNT_W wide, and never wraps. Decrement is gated at zero. len = 2^CNT_W-1 is legal.
- Reset values: state=IDLE, ptr=0, grant=0, done=0, busy=0, q=0.
- Reset during COUNT or DONE: the next cycle is IDLE with all outputs at reset values. No done is emitted.

## Timing
- A request seen in IDLE at cycle T gives grant and q=len at T+1.
- q reaches 0 at T+1+len. done is high at T+2+len. grant falls at T+3+len.
- grant is high for len+2 cycles. len=0 gives done at T+2.
- At least one IDLE cycle separates consecutive grants, so the minimum grant-to-grant period is len+3.
- Outputs are registered; there is no combinational path from req to grant.
- `busy` equals OR-reduce of grant.

## Configuration
- COUNTER_SCHED_ABORT_EN
- **Defined:**
  - The abort port exists.
  - abort=1 in COUNT means the next cycle is IDLE with grant=0, busy=0, q=0, and no done pulse. ptr still advances past the aborted requester.
  - abort in IDLE or DONE is ignored. DONE always completes.
- **Undefined:** the port is absent and intervals always complete.

## Structure
- Package counter_sched_pkg:
  - state typedef enum with IDLE, COUNT, DONE.
  - default CNT_W and NUM_REQ constants.
  - a round-robin select function (req, ptr) returning a one-hot value.
- Sub-module sched_down_counter:
  - Inputs: clk, rst, load, load_val, en.
  - Outputs: q, zero.
  - Saturates at zero.
- counter_sched instantiates one sched_down_counter.

## Test plan
- **Reset, then single request:** req=4'b0001 and len0=3 at T. Expect grant=0001 at T+1, q sequence 3,2,1,0, done[0] at T+5, grant=0 at T+6.
- **Round-robin with all requesting:** req=1111 and all len=1, held. Expect grant order 0,1,2,3,0, with each grant 3 cycles long and separated by 1 IDLE cycle.
- **len=0:** done pulses 2 cycles after the request cycle. Separately, len=15 with CNT_W=4: q counts 15 down to 0 with no wrap.
- **Drop req and change len mid-count:** the interval still runs the original len and done still pulses.
- **rst asserted in COUNT with q=2:** all outputs 0 on the next cycle, no done, and ptr=0, so requester 0 wins next.
- **With COUNTER_SCHED_ABORT_EN, abort while requester 2 is counting:** IDLE next cycle, no done, and requester 3 has priority in the following arbitration.
